// File: rtl/hw_mutex_core_if_pkg.sv
// hw_mutex_core_if_pkg: shared state, op and response-code definitions for the mutex core front end
package hw_mutex_core_if_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} core_state_e;
   localparam logic OP_LOCK   = 1'b1;
   localparam logic OP_UNLOCK = 1'b0;
   localparam logic OPC_OK    = 1'b0;
   localparam logic OPC_ERR   = 1'b1;
endpackage

// File: rtl/hw_mutex_core_if_if.sv
// hw_mutex_core_if_if: core-bus and mutex-unit signals of the per-core mutex front end
interface hw_mutex_core_if_if #(
   parameter int NB_CORES    = 4,
   parameter int MUTEX_MSG_W = 32
);
   logic [NB_CORES-1:0]             core_req_i, core_wen_i, core_gnt_o, core_r_valid_o, core_r_opc_o;
   logic [NB_CORES-1:0]             lock_req_o, unlock_req_o, mutex_event_i;
   logic [NB_CORES*MUTEX_MSG_W-1:0] core_wdata_i, core_r_rdata_o;
   logic [MUTEX_MSG_W-1:0]          mutex_msg_wdata_o, mutex_msg_rdata_i;
   modport master (
      output core_req_i, core_wen_i, core_wdata_i, mutex_msg_rdata_i, mutex_event_i,
      input  core_gnt_o, core_r_valid_o, core_r_opc_o, core_r_rdata_o,
      input  lock_req_o, unlock_req_o, mutex_msg_wdata_o
   );
   modport slave (
      input  core_req_i, core_wen_i, core_wdata_i, mutex_msg_rdata_i, mutex_event_i,
      output core_gnt_o, core_r_valid_o, core_r_opc_o, core_r_rdata_o,
      output lock_req_o, unlock_req_o, mutex_msg_wdata_o
   );
endinterface

// File: rtl/hw_mutex_core_fsm.sv
// hw_mutex_core_fsm: one core's lock/unlock handshake, blocking-lock wait and one-cycle response
module hw_mutex_core_fsm
   import hw_mutex_core_if_pkg::*;
#(
   parameter int MUTEX_MSG_W = 32,
   parameter int CORE_IDX    = 0
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   i_req,
   input  logic                   i_wen,
   input  logic                   i_is_owner,
   input  logic                   i_event,
   input  logic [MUTEX_MSG_W-1:0] i_msg_rdata,
   output logic                   o_gnt,
   output logic                   o_r_valid,
   output logic                   o_r_opc,
   output logic [MUTEX_MSG_W-1:0] o_r_rdata,
   output logic                   o_lock_req,
   output logic                   o_unlock_req
);
   core_state_e r_state, w_state;
   logic        r_opc, w_opc, r_lock_ok, w_lock_ok;
   assign o_gnt        = i_req && r_state == IDLE;
   assign o_lock_req   = o_gnt && i_wen == OP_LOCK && !i_is_owner;
   assign o_unlock_req = o_gnt && i_wen == OP_UNLOCK && i_is_owner;
   assign o_r_valid    = r_state == RESP;
   assign o_r_opc      = o_r_valid && r_opc == OPC_ERR;
   assign o_r_rdata    = (o_r_valid && r_lock_ok) ? i_msg_rdata : '0;
   always_comb begin
      w_state   = r_state;
      w_opc     = r_opc;
      w_lock_ok = r_lock_ok;
      if (o_gnt) begin
         w_state   = (o_lock_req && !i_event) ? WAIT : RESP;
         // recursive lock and non-owner unlock are the two rejected cases
         w_opc     = ((i_wen == OP_LOCK) == i_is_owner) ? OPC_ERR : OPC_OK;
         w_lock_ok = o_lock_req;
      end else if (r_state == WAIT) w_state = i_event ? RESP : WAIT;
      else if (r_state == RESP) w_state = IDLE;
   end
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state   <= IDLE;
         r_opc     <= OPC_OK;
         r_lock_ok <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_opc     <= w_opc;
         r_lock_ok <= w_lock_ok;
      end
   end
   a_event_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
      i_event |-> (r_state == WAIT || o_lock_req))
      else $error("hw_mutex_core_fsm %0d: mutex event while not waiting", CORE_IDX);
endmodule

// File: rtl/hw_mutex_core_if.sv
// hw_mutex_core_if: per-core front end of the hardware mutex; tracks the owner and muxes the unlock message
module hw_mutex_core_if
   import hw_mutex_core_if_pkg::*;
#(
   parameter int NB_CORES    = 4,
   parameter int MUTEX_MSG_W = 32
) (
   input logic                clk_i,
   input logic                rst_ni,
   hw_mutex_core_if_if.slave  bus
);
   localparam int IDX_W = NB_CORES > 1 ? $clog2(NB_CORES) : 1;
   logic                            r_owner_vld;
   logic [IDX_W-1:0]                r_owner_idx, w_ev_idx;
   logic [NB_CORES-1:0]             w_is_owner, w_gnt, w_r_valid, w_r_opc, w_lock, w_unlock;
   logic [NB_CORES*MUTEX_MSG_W-1:0] w_r_rdata;
   logic [MUTEX_MSG_W-1:0]          w_wdata;
   for (genvar g = 0; g < NB_CORES; g++) begin : g_core
      assign w_is_owner[g] = r_owner_vld && r_owner_idx == IDX_W'(g);
      hw_mutex_core_fsm #(.MUTEX_MSG_W(MUTEX_MSG_W), .CORE_IDX(g)) u_fsm (
         .clk_i        (clk_i),
         .rst_ni       (rst_ni),
         .i_req        (bus.core_req_i[g]),
         .i_wen        (bus.core_wen_i[g]),
         .i_is_owner   (w_is_owner[g]),
         .i_event      (bus.mutex_event_i[g]),
         .i_msg_rdata  (bus.mutex_msg_rdata_i),
         .o_gnt        (w_gnt[g]),
         .o_r_valid    (w_r_valid[g]),
         .o_r_opc      (w_r_opc[g]),
         .o_r_rdata    (w_r_rdata[g*MUTEX_MSG_W +: MUTEX_MSG_W]),
         .o_lock_req   (w_lock[g]),
         .o_unlock_req (w_unlock[g])
      );
   end
   // only the owner can pulse an unlock, so at most one slice is ever selected
   always_comb begin
      w_wdata  = '0;
      w_ev_idx = '0;
      for (int k = 0; k < NB_CORES; k++) begin
         if (w_unlock[k]) w_wdata = bus.core_wdata_i[k*MUTEX_MSG_W +: MUTEX_MSG_W];
         if (bus.mutex_event_i[k]) w_ev_idx = IDX_W'(k);
      end
   end
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_owner_vld <= 1'b0;
         r_owner_idx <= '0;
      end else if (|bus.mutex_event_i) begin
         r_owner_vld <= 1'b1;
         r_owner_idx <= w_ev_idx;
      end else if (|w_unlock) r_owner_vld <= 1'b0;
   end
   assign bus.core_gnt_o        = w_gnt;
   assign bus.core_r_valid_o    = w_r_valid;
   assign bus.core_r_opc_o      = w_r_opc;
   assign bus.core_r_rdata_o    = w_r_rdata;
   assign bus.lock_req_o        = w_lock;
   assign bus.unlock_req_o      = w_unlock;
   assign bus.mutex_msg_wdata_o = w_wdata;
endmodule

// File: tb/tb_hw_mutex_core_if.sv
// tb_hw_mutex_core_if: directed plus random bus traffic against a transaction-level mutex model
module tb_hw_mutex_core_if;
   localparam int N  = 4;
   localparam int W  = 32;
   localparam int CW = N * W;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   always #5 clk = ~clk;
   hw_mutex_core_if_if #(.NB_CORES(N), .MUTEX_MSG_W(W)) bus ();
   hw_mutex_core_if #(.NB_CORES(N), .MUTEX_MSG_W(W)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus.slave)
   );
   // mutex unit: lowest-index requester wins when the mutex is free or being released
   logic [N-1:0] mu_pend, ev, cand;
   logic         mu_busy, free;
   logic [W-1:0] mu_msg;
   always_comb begin
      cand = mu_pend | bus.lock_req_o;
      free = !mu_busy || (|bus.unlock_req_o);
      ev   = '0;
      for (int i = N - 1; i >= 0; i--) if (rst_n && free && cand[i]) ev = N'(1) << i;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mu_pend <= '0;
         mu_busy <= 1'b0;
         mu_msg  <= '0;
      end else begin
         mu_pend <= cand & ~ev;
         mu_busy <= (|ev) || (mu_busy && !(|bus.unlock_req_o));
         if (|bus.unlock_req_o) mu_msg <= bus.mutex_msg_wdata_o;
      end
   end
   assign bus.mutex_event_i     = ev;
   assign bus.mutex_msg_rdata_i = mu_msg;
   // reference model: owner, blocked locks, and responses due in the current cycle
   int           m_owner = -1;
   bit [N-1:0]   m_blocked = '0, m_due = '0, m_err = '0, m_got = '0;
   logic [W-1:0] m_msg = '0;
   task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask
   task automatic cyc(input logic rn, input logic [N-1:0] req, input logic [N-1:0] wen, input logic [CW-1:0] wd);
      logic [N-1:0]  g, lk, ul, e;
      logic [W-1:0]  wexp;
      logic [CW-1:0] rd;
      rst_n = rn;
      bus.core_req_i = req;
      bus.core_wen_i = wen;
      bus.core_wdata_i = wd;
      @(negedge clk);
      e = ev;
      wexp = '0;
      rd = '0;
      for (int k = 0; k < N; k++) begin
         g[k]  = req[k] && !m_blocked[k] && !m_due[k];
         lk[k] = g[k] && wen[k] && m_owner != k;
         ul[k] = g[k] && !wen[k] && m_owner == k;
         if (ul[k]) wexp = wd[k*W +: W];
         if (m_due[k] && m_got[k]) rd[k*W +: W] = m_msg;
      end
      chk("gnt", CW'(bus.core_gnt_o), CW'(g));
      chk("lock_req", CW'(bus.lock_req_o), CW'(lk));
      chk("unlock_req", CW'(bus.unlock_req_o), CW'(ul));
      chk("msg_wdata", CW'(bus.mutex_msg_wdata_o), CW'(wexp));
      chk("r_valid", CW'(bus.core_r_valid_o), CW'(m_due));
      chk("r_opc", CW'(bus.core_r_opc_o), CW'(m_due & m_err));
      chk("r_rdata", bus.core_r_rdata_o, rd);
      chk("owner_vld", CW'(dut.r_owner_vld), CW'(m_owner >= 0));
      if (m_owner >= 0) chk("owner_idx", CW'(dut.r_owner_idx), CW'(m_owner));
      @(posedge clk);
      if (!rn) begin
         m_owner = -1;
         m_blocked = '0;
         m_due = '0;
         m_err = '0;
         m_got = '0;
         m_msg = '0;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (g[k]) begin
               m_err[k] = wen[k] ? (m_owner == k) : (m_owner != k);
               m_got[k] = lk[k];
            end
            m_due[k] = (g[k] && !(lk[k] && !e[k])) || (m_blocked[k] && e[k]);
            m_blocked[k] = (m_blocked[k] || lk[k]) && !e[k];
         end
         if (|ul) m_msg = wexp;
         if (|e) begin
            for (int k = 0; k < N; k++) if (e[k]) m_owner = k;
         end else if (|ul) m_owner = -1;
      end
      #1;
   endtask
   initial begin
      bus.core_req_i = '0;
      bus.core_wen_i = '0;
      bus.core_wdata_i = '0;
      cyc(1'b0, 4'b0000, 4'b0000, '0);
      cyc(1'b0, 4'b0000, 4'b0000, '0);
      cyc(1'b1, 4'b0000, 4'b0000, '0);
      cyc(1'b1, 4'b0001, 4'b0001, '0);
      cyc(1'b1, 4'b0000, 4'b0000, '0);
      cyc(1'b1, 4'b0100, 4'b0100, '0);
      cyc(1'b1, 4'b0000, 4'b0000, '0);
      cyc(1'b1, 4'b0000, 4'b0000, '0);
      cyc(1'b1, 4'b0001, 4'b0000, {96'h0, 32'hCAFE0001});
      cyc(1'b1, 4'b0000, 4'b0000, '0);
      cyc(1'b1, 4'b0100, 4'b0000, {32'h0, 32'h22220002, 64'h0});
      cyc(1'b1, 4'b0000, 4'b0000, '0);
      cyc(1'b1, 4'b1010, 4'b1010, '0);
      cyc(1'b1, 4'b0000, 4'b0000, '0);
      cyc(1'b1, 4'b0000, 4'b0000, '0);
      cyc(1'b1, 4'b0010, 4'b0000, {64'h0, 32'h11110001, 32'h0});
      cyc(1'b1, 4'b0000, 4'b0000, '0);
      cyc(1'b1, 4'b1000, 4'b0000, {32'h33330003, 96'h0});
      cyc(1'b1, 4'b0000, 4'b0000, '0);
      cyc(1'b1, 4'b0010, 4'b0010, '0);
      cyc(1'b1, 4'b0000, 4'b0000, '0);
      cyc(1'b1, 4'b1000, 4'b0000, {32'hDEAD0003, 96'h0});
      cyc(1'b1, 4'b0000, 4'b0000, '0);
      cyc(1'b1, 4'b0010, 4'b0010, '0);
      cyc(1'b1, 4'b0000, 4'b0000, '0);
      cyc(1'b1, 4'b0100, 4'b0100, '0);
      cyc(1'b1, 4'b0000, 4'b0000, '0);
      cyc(1'b0, 4'b0000, 4'b0000, '0);
      cyc(1'b1, 4'b0100, 4'b0100, '0);
      cyc(1'b1, 4'b0000, 4'b0000, '0);
      for (int c = 0; c < 2000; c++) begin
         logic [N-1:0]  rq, wn;
         logic [CW-1:0] wd;
         for (int k = 0; k < N; k++) begin
            rq[k] = $urandom_range(0, 2) == 0;
            wn[k] = $urandom_range(0, 1) == 1;
            wd[k*W +: W] = $urandom;
         end
         cyc($urandom_range(0, 199) != 0, rq, wn, wd);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/hw_mutex_core_if.md
Name: hw_mutex_core_if

Overview:
- Per-core front end that sits directly upstream of the hardware mutex unit in the event unit.
- Converts each core's peripheral-bus accesses into single-cycle lock/unlock pulses and the unlock message.
- A lock is a blocking read: the response is held back until the mutex unit assigns the mutex to that core, and the response returns the mutex message.
- Also tracks the current owner so that unlocks from non-owners and recursive locks are rejected.

Parameters:
- NB_CORES, 4, number of cores / request ports.
- MUTEX_MSG_W, 32, width of the mutex message and of the bus data.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- core_req_i  in  NB_CORES  per-core request valid.
- core_wen_i  in  NB_CORES  per-core op: 1 = lock (read), 0 = unlock (write).
- core_wdata_i  in  NB_CORES*MUTEX_MSG_W  per-core unlock message, core k in slice k.
- core_gnt_o  out  NB_CORES  request accepted.
- core_r_valid_o  out  NB_CORES  response valid, one-cycle pulse.
- core_r_rdata_o  out  NB_CORES*MUTEX_MSG_W  response data.
- core_r_opc_o  out  NB_CORES  response error (1 = rejected).
- lock_req_o  out  NB_CORES  to mutex unit, one-cycle lock pulse.
- unlock_req_o  out  NB_CORES  to mutex unit, one-cycle unlock pulse.
- mutex_msg_wdata_o  out  MUTEX_MSG_W  to mutex unit, message accompanying an unlock.
- mutex_msg_rdata_i  in  MUTEX_MSG_W  from mutex unit, registered message.
- mutex_event_i  in  NB_CORES  from mutex unit, one-hot assignment (same cycle as the winning lock or unlock).

Behaviour:
- Per-core FSM with states IDLE, WAIT, RESP.
- Reset (synchronous, rst_ni=0 at a clock edge): all FSMs go to IDLE and ownership is cleared. All registered outputs are 0. Pending blocked locks are dropped; the mutex unit shares the same reset.
- core_gnt_o[k] = core_req_i[k] & (FSM_k==IDLE), combinational. No request is accepted outside IDLE.
- Lock accepted in IDLE:
  - If core k is the current owner (recursive lock): no pulse; go to RESP with opc=1.
  - Otherwise lock_req_o[k]=1 in the accept cycle, combinational from the grant.
  - If mutex_event_i[k]=1 in the same cycle, go to RESP; else go to WAIT.
- WAIT: stay until mutex_event_i[k]=1, then go to RESP. No timeout.
- RESP: core_r_valid_o[k]=1 for exactly one cycle, then return to IDLE.
  - core_r_rdata_o[k] = mutex_msg_rdata_i combinationally for a successful lock. This is the message written by the previous holder, since the mutex unit registers it on the unlock cycle.
  - core_r_rdata_o[k] = 0 for unlocks and for errors.
- Unlock accepted in IDLE:
  - If core k is the current owner: unlock_req_o[k]=1 and mutex_msg_wdata_o = slice k of core_wdata_i in the same cycle; go to RESP with opc=0.
  - If not the owner: no pulse; go to RESP with opc=1.
- mutex_msg_wdata_o = 0 when no unlock is pulsed. At most one valid unlock can exist per cycle, because only the owner may unlock.
- Ownership registers owner_vld (1 bit) and owner_idx ($clog2(NB_CORES) bits):
  - Any mutex_event_i bit set: owner_vld=1, owner_idx = index of that bit. This takes priority over a same-cycle owner unlock, i.e. a handoff.
  - Owner unlock with no event in the same cycle: owner_vld=0.
- Simultaneous requests:
  - Several cores may lock in the same cycle; all pulses pass through and the mutex unit arbitrates.
  - Lock by core j and unlock by owner k in the same cycle are both pulsed; the event selects the next owner.
- Error response: core_r_opc_o[k]=1 is registered per core and valid only together with core_r_valid_o[k].
- mutex_event_i asserted for a core that is not in WAIT and not accepting a lock: illegal input. Ownership is still updated; the core's FSM is unaffected. An assertion flags it in simulation.

Decomposition:
- Package: an enum for the core FSM states (IDLE/WAIT/RESP), the op encoding constants (LOCK=1, UNLOCK=0), and an opc error constant.
- Natural sub-module: hw_mutex_core_fsm, one instance per core via generate. It holds the FSM, the response registers and the handshake logic.
- Ownership tracking and the wdata mux stay in the top level.
- Each instance is parameterised by MUTEX_MSG_W and its core index, and receives an is_owner input from the top level.

Test Plan (all with NB_CORES=4, connected to the mutex unit):
- Core 0 locks while the mutex is free at T.
  - Required: gnt at T, lock_req_o=0001 at T, r_valid[0] at T+1 with rdata=0 (message after reset), owner=0.
- Core 2 locks while core 0 owns: core 2 is granted and stays in WAIT, no r_valid. Core 0 then unlocks with wdata=0xCAFE0001 at T.
  - Required: unlock_req_o=0001 and mutex_msg_wdata_o=0xCAFE0001 at T; r_valid[0] opc=0 at T+1.
  - Required: r_valid[2] at T+1 with rdata=0xCAFE0001; owner=2.
- Cores 1 and 3 both lock in the same cycle on a free mutex.
  - Required: lock_req_o=1010; core 1 responds at T+1 and owns; core 3 stays in WAIT until core 1 unlocks.
- Core 3 unlocks while core 1 owns.
  - Required: no unlock_req_o, r_valid[3] with opc=1, ownership unchanged.
  - Core 1 then locks again: lock rejected with opc=1, no lock_req_o.
- rst_ni=0 for 1 cycle while core 2 is in WAIT.
  - Required: all outputs 0 next cycle, owner_vld=0, core 2 back in IDLE and able to lock again immediately.
